// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for the iterative DES decryption core.
// Source drives cipher/key in, sink takes plaintext out.
interface des_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain;
    logic        busy;

    modport master (
        output in_valid,
        output cipher,
        output key,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  plain,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  cipher,
        input  key,
        input  out_ready,
        output in_ready,
        output out_valid,
        output plain,
        output busy
    );
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core, FIPS 46-3 bit order (bit 1 = MSB).
// One shared Feistel datapath runs ROUNDS_PER_CYCLE rounds per clock.
module des_decrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic clk,
    input logic rst_n,
    des_decrypt_iter_if.slave bus
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8 ||
              ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] RPC5 = 5'(ROUNDS_PER_CYCLE);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // S1..S8, each 4 rows of 16, indexed box*64 + row*16 + col
    localparam int SB_T [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] r);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = r[32-E_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] s);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    // Outer bits of each 6-bit group select the row, inner four the column
    function automatic logic [31:0] f_f(
        input logic [31:0] r,
        input logic [47:0] k
    );
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int          idx;
        x = e_f(r) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = b * 64 + 32'({six[5], six[0], six[4:1]});
            s[31-4*b -: 4] = 4'(SB_T[idx]);
        end
        return p_f(s);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [4:0]  ctr_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [63:0] plain_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    logic [4:0]  ctr_d;
    logic [31:0] l_d;
    logic [31:0] r_d;
    logic [27:0] c_d;
    logic [27:0] d_d;
    logic [4:0]  n_w;
    logic [47:0] k_w;
    logic [31:0] t_w;
    logic [63:0] ip_w;
    logic [55:0] cd0_w;

    assign ip_w  = ip_f(bus.cipher);
    assign cd0_w = pc1_f(bus.key);

    // Unrolled decrypt rounds: right rotations walk the schedule K16..K1
    always_comb begin
        l_d   = l_q;
        r_d   = r_q;
        c_d   = c_q;
        d_d   = d_q;
        n_w   = '0;
        k_w   = '0;
        t_w   = '0;
        ctr_d = ctr_q + RPC5;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            n_w = ctr_q + 5'(j + 1);
            if (n_w == 5'd2 || n_w == 5'd9 || n_w == 5'd16) begin
                c_d = {c_d[0], c_d[27:1]};
                d_d = {d_d[0], d_d[27:1]};
            end else if (n_w != 5'd1) begin
                c_d = {c_d[1:0], c_d[27:2]};
                d_d = {d_d[1:0], d_d[27:2]};
            end
            k_w = pc2_f({c_d, d_d});
            t_w = r_d;
            r_d = l_d ^ f_f(r_d, k_w);
            l_d = t_w;
        end
    end

    // Control FSM with registered handshake outputs and round state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctr_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            plain_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        l_q        <= ip_w[63:32];
                        r_q        <= ip_w[31:0];
                        c_q        <= cd0_w[55:28];
                        d_q        <= cd0_w[27:0];
                        ctr_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    ctr_q <= ctr_d;
                    if (ctr_d == 5'd16) begin
                        plain_q     <= fp_f({r_d, l_d});
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plain     = plain_q;
    assign bus.busy      = busy_q;

endmodule
